// File: rtl/image_stream_pkg.sv
// Shared constants and state type for the image streamer.
package image_stream_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned WORD_W       = 128;
    localparam int unsigned PIX_PER_WORD = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned ADDR_W_DEF   = 13;
    localparam int unsigned CSUM_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } stream_state_e;

endpackage

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: holds one captured memory word and presents its bytes
// low byte first, advancing one byte per accepted pixel.
module pixel_unpacker
    import image_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              final_i,
    input  logic              advance_i,
    output logic [PIX_W-1:0]  pix_data_o,
    output logic              pix_last_o,
    output logic              last_byte_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              fw_q, fw_d;
    logic              lastb_q, lastb_d;
    logic              plast_q, plast_d;

    // Next word/index; the presented byte is pre-selected so pix_data is a flop.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        fw_d   = fw_q;
        if (capture_i) begin
            word_d = word_i;
            idx_d  = '0;
            fw_d   = final_i;
        end else if (advance_i) begin
            idx_d = idx_q + IDX_W'(1);
        end
        pix_d   = word_d[{idx_d, 3'b000} +: PIX_W];
        lastb_d = (idx_d == IDX_W'(PIX_PER_WORD - 1));
        plast_d = lastb_d && fw_d;
    end

    // Capture register and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            pix_q   <= '0;
            fw_q    <= 1'b0;
            lastb_q <= 1'b0;
            plast_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            pix_q   <= pix_d;
            fw_q    <= fw_d;
            lastb_q <= lastb_d;
            plast_q <= plast_d;
        end
    end

    assign pix_data_o  = pix_q;
    assign pix_last_o  = plast_q;
    assign last_byte_o = lastb_q;

endmodule

// File: rtl/image_streamer.sv
// image_streamer: reads word_count 128-bit words from the image memory and
// streams them out as bytes over a valid/ready pixel interface.
// Optional build macro STREAMER_CHECKSUM_EN adds a 16-bit pixel checksum output.
module image_streamer
    import image_stream_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done
`ifdef STREAMER_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] checksum
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LAT_W = 3;

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              pix_valid_q, pix_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic start_acc;
    logic lat_done;
    logic capture;
    logic handshake;
    logic last_byte;
    logic final_word;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign lat_done   = (lat_q == LAT_W'(RD_LAT - 1));
    assign capture    = (state_q == ST_WAIT) && lat_done;
    assign handshake  = pix_valid_q && pix_ready;
    assign final_word = (remain_q == '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (word_count == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  if (lat_done) state_d = ST_SHIFT;
            ST_SHIFT: if (handshake && last_byte) state_d = final_word ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values; addr/remain advance as each fetch issues.
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        lat_d      = lat_q;
        mem_addr_d = mem_addr_q;
        if (start_acc) begin
            addr_d   = base_addr;
            remain_d = word_count;
        end
        if (state_q == ST_FETCH) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - CNT_W'(1);
            lat_d    = '0;
        end
        if (state_q == ST_WAIT) lat_d = lat_q + LAT_W'(1);
        if (state_d == ST_FETCH) mem_addr_d = addr_d;
        mem_rd_en_d = (state_d == ST_FETCH);
        pix_valid_d = (state_d == ST_SHIFT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            remain_q    <= '0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    pixel_unpacker u_unpacker (
        .clk         (clk),
        .rst_n       (reset),
        .capture_i   (capture),
        .word_i      (mem_rdata),
        .final_i     (final_word),
        .advance_i   (handshake),
        .pix_data_o  (pix_data),
        .pix_last_o  (pix_last),
        .last_byte_o (last_byte)
    );

`ifdef STREAMER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;

    // Running pixel sum: cleared on an accepted start, accumulated per handshake.
    always_comb begin
        csum_d = csum_q;
        if (start_acc)      csum_d = '0;
        else if (handshake) csum_d = csum_q + CSUM_W'(pix_data);
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer (optionally with STREAMER_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_image_streamer;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 13;
    localparam int CW     = ADDR_W + 1;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W-1:0] base_addr  = '0;
    logic [CW-1:0]     word_count = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [127:0]      mem_rdata;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready  = 1'b1;
    logic              pix_last;
    logic              busy;
    logic              done;
`ifdef STREAMER_CHECKSUM_EN
    logic [15:0]       checksum;
    logic [15:0]       done_csum[$];
`endif

    int checks = 0;
    int errors = 0;
    int pcnt   = 0;
    int salt   = 0;
    bit all_ff = 1'b0;
    int rmode  = 0;

    image_streamer #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
`ifdef STREAMER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory content rule: byte k of word a.
    function automatic logic [7:0] exp_byte(input int a, input int k, input int s, input bit ff);
        if (ff) return 8'hFF;
        return 8'(a * 16 + k + s);
    endfunction

    function automatic logic [127:0] mk_word(input int a, input int s, input bit ff);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[k*8 +: 8] = exp_byte(a, k, s, ff);
        return w;
    endfunction

    // Memory with RD_LAT-cycle latency; returns junk when no read is due.
    logic [ADDR_W-1:0] pa [RD_LAT];
    logic              pv [RD_LAT];
    logic [127:0]      garbage = '0;
    always @(posedge clk) begin
        pv[0] <= mem_rd_en;
        pa[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        garbage <= {$urandom, $urandom, $urandom, $urandom};
    end
    assign mem_rdata = (pv[RD_LAT-1] === 1'b1) ? mk_word(int'(pa[RD_LAT-1]), salt, all_ff) : garbage;

    // Sink ready pattern: 0 always ready, 1 toggling, 2 random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = pcnt[0];
            default: pix_ready = ($urandom_range(0, 99) < 65);
        endcase
    end

    // Monitor: records transfers, reads and pulses with absolute cycle stamps.
    logic [7:0] px_q[$];
    bit         lst_q[$];
    int         px_cyc[$];
    int         rd_q[$];
    int         rd_cyc[$];
    int         done_cyc[$];
    int         busy_cyc[$];
    int         valid_n   = 0;
    int         hold_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    always @(negedge clk) begin
        if (prev_stall && reset && !(pix_valid === 1'b1 && pix_data === prev_d && pix_last === prev_l))
            hold_viol++;
        prev_stall = (pix_valid === 1'b1) && (pix_ready === 1'b0) && reset;
        prev_d = pix_data;
        prev_l = pix_last;
        if (mem_rd_en === 1'b1) begin rd_q.push_back(int'(mem_addr)); rd_cyc.push_back(pcnt); end
        if (pix_valid === 1'b1) valid_n++;
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            px_q.push_back(pix_data);
            lst_q.push_back(pix_last);
            px_cyc.push_back(pcnt);
        end
        if (done === 1'b1) begin
            done_cyc.push_back(pcnt);
`ifdef STREAMER_CHECKSUM_EN
            done_csum.push_back(checksum);
`endif
        end
        if (busy === 1'b1) busy_cyc.push_back(pcnt);
    end

    // Reference pixel stream computed from base/count.
    logic [7:0] exp_q[$];
    task automatic build_exp(input int b, input int c);
        exp_q.delete();
        for (int w = 0; w < c; w++)
            for (int k = 0; k < 16; k++)
                exp_q.push_back(exp_byte((b + w) & AMASK, k, salt, all_ff));
    endtask

    task automatic launch(input int b, input int c, output int t0);
        @(posedge clk); #1;
        px_q.delete(); lst_q.delete(); px_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        done_cyc.delete(); busy_cyc.delete();
`ifdef STREAMER_CHECKSUM_EN
        done_csum.delete();
`endif
        valid_n = 0; hold_viol = 0;
        base_addr  = ADDR_W'(b);
        word_count = CW'(c);
        @(negedge clk);
        start = 1'b1;
        t0 = pcnt;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ADDR_W'($urandom);
        word_count = CW'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cyc.size() > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({pix_valid, pix_last, busy, done, mem_rd_en} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {pix_valid, pix_last, busy, done, mem_rd_en}); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
        checks++; if (pix_data !== '0) begin errors++; $display("FAIL reset_pix: got %0h expected 0", pix_data); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int t0; bit ok;
        salt = 0; all_ff = 1'b0; rmode = 0;
        launch(16'h0010, 1, t0);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (rd_q.size() != 1 || rd_q[0] != 'h10 || rd_cyc[0] - t0 != 1) begin errors++;
            $display("FAIL basic_read: got %0d reads expected 1 read of 0x10 in cycle 1", rd_q.size()); end
        checks++; if (px_q.size() != 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", px_q.size()); end
        for (int k = 0; k < px_q.size() && k < 16; k++) begin
            checks++; if (px_q[k] !== 8'(k) || px_cyc[k] - t0 != 4 + k || lst_q[k] != (k == 15)) begin errors++;
                $display("FAIL basic_px%0d: got %0h cyc %0d last %0b expected %0h cyc %0d last %0b",
                         k, px_q[k], px_cyc[k] - t0, lst_q[k], k, 4 + k, k == 15); end
        end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] - t0 != 20) begin errors++;
            $display("FAIL basic_done: got %0d pulses expected 1 in cycle 20", done_cyc.size()); end
        checks++; if (busy_cyc.size() != 20 || busy_cyc[0] - t0 != 1) begin errors++;
            $display("FAIL basic_busy: got %0d busy cycles expected 20", busy_cyc.size()); end
    endtask

    task automatic test_toggle();
        int t0; bit ok;
        salt = $urandom_range(0, 255); all_ff = 1'b0; rmode = 1;
        build_exp('h10, 3);
        launch('h10, 3, t0);
        wait_done(400, ok);
        rmode = 0;
        checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout: got no done expected done"); end
        checks++; if (px_q.size() != 48) begin errors++; $display("FAIL toggle_count: got %0d expected 48", px_q.size()); end
        for (int i = 0; i < px_q.size() && i < 48; i++) begin
            checks++; if (px_q[i] !== exp_q[i] || lst_q[i] != (i == 47)) begin errors++;
                $display("FAIL toggle_px%0d: got %0h last %0b expected %0h last %0b", i, px_q[i], lst_q[i], exp_q[i], i == 47); end
        end
        checks++; if (rd_q.size() != 3 || rd_q[0] != 'h10 || rd_q[1] != 'h11 || rd_q[2] != 'h12) begin errors++;
            $display("FAIL toggle_reads: got %0d reads expected 0x10,0x11,0x12", rd_q.size()); end
        checks++; if (hold_viol != 0 || valid_n <= 48) begin errors++;
            $display("FAIL toggle_hold: got %0d violations, %0d valid cycles expected 0 and >48", hold_viol, valid_n); end
    endtask

    task automatic test_wrap();
        int t0; bit ok;
        salt = $urandom_range(0, 255); all_ff = 1'b0; rmode = 2;
        build_exp(AMASK, 2);
        launch(AMASK, 2, t0);
        wait_done(400, ok);
        rmode = 0;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done expected done"); end
        checks++; if (rd_q.size() != 2 || rd_q[0] != AMASK || rd_q[1] != 0) begin errors++;
            $display("FAIL wrap_reads: got %0d reads expected 0x1fff then 0", rd_q.size()); end
        checks++; if (px_q.size() != 32) begin errors++; $display("FAIL wrap_count: got %0d expected 32", px_q.size()); end
        for (int i = 0; i < px_q.size() && i < 32; i++) begin
            checks++; if (px_q[i] !== exp_q[i] || lst_q[i] != (i == 31)) begin errors++;
                $display("FAIL wrap_px%0d: got %0h last %0b expected %0h last %0b", i, px_q[i], lst_q[i], exp_q[i], i == 31); end
        end
    endtask

    task automatic test_zero();
        int t0; bit ok;
        launch($urandom_range(0, AMASK), 0, t0);
        wait_done(20, ok);
        checks++; if (!ok || done_cyc[0] - t0 != 1) begin errors++; $display("FAIL zero_done: got ok=%0b expected done in cycle 1", ok); end
        checks++; if (rd_q.size() != 0 || valid_n != 0) begin errors++;
            $display("FAIL zero_activity: got %0d reads %0d valid expected 0 0", rd_q.size(), valid_n); end
        checks++; if (busy_cyc.size() != 1 || busy_cyc[0] - t0 != 1) begin errors++;
            $display("FAIL zero_busy: got %0d busy cycles expected 1 in cycle 1", busy_cyc.size()); end
    endtask

    task automatic test_abort();
        int t0; bit ok; int nrd; int ndone; int b;
        salt = $urandom_range(0, 255); all_ff = 1'b0; rmode = 0;
        b = $urandom_range(0, AMASK);
        launch(b, 3, t0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (px_q.size() >= 23) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_reach: got %0d pixels expected 23", px_q.size()); end
        @(posedge clk); #2;
        checks++; if (pix_valid !== 1'b1 || pix_data !== exp_byte((b + 1) & AMASK, 7, salt, 1'b0)) begin errors++;
            $display("FAIL abort_px7: got %0h expected %0h", pix_data, exp_byte((b + 1) & AMASK, 7, salt, 1'b0)); end
        reset = 1'b0;
        #1;
        checks++; if ({pix_valid, pix_last, busy, done, mem_rd_en} !== 5'b0 || pix_data !== '0 || mem_addr !== '0) begin errors++;
            $display("FAIL abort_async: got ctrl %b pix %0h addr %0h expected all 0",
                     {pix_valid, pix_last, busy, done, mem_rd_en}, pix_data, mem_addr); end
        nrd = rd_q.size(); ndone = done_cyc.size();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin errors++;
            $display("FAIL abort_idle: got busy %b valid %b expected 0 0", busy, pix_valid); end
        repeat (4) @(negedge clk); #1;
        checks++; if (rd_q.size() != nrd || done_cyc.size() != ndone) begin errors++;
            $display("FAIL abort_quiet: got %0d reads %0d done expected %0d %0d", rd_q.size(), done_cyc.size(), nrd, ndone); end
        b = $urandom_range(0, AMASK);
        build_exp(b, 1);
        launch(b, 1, t0);
        wait_done(100, ok);
        checks++; if (!ok || rd_q.size() != 1 || rd_q[0] != b || done_cyc[0] - t0 != 20) begin errors++;
            $display("FAIL abort_restart: got ok=%0b %0d reads expected 1 read and done in cycle 20", ok, rd_q.size()); end
        checks++; if (px_q != exp_q || lst_q.size() != 16 || lst_q[15] != 1'b1) begin errors++;
            $display("FAIL abort_stream: got %0d pixels expected 16 matching", px_q.size()); end
    endtask

    task automatic test_busy_start();
        int t0; bit ok; int b;
        salt = $urandom_range(0, 255); all_ff = 1'b0; rmode = 0;
        b = $urandom_range(0, AMASK);
        launch(b, 2, t0);
        repeat (3) @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(b + 100); word_count = CW'(5);
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(200, ok);
        repeat (5) @(negedge clk); #1;
        checks++; if (!ok || done_cyc.size() != 1) begin errors++;
            $display("FAIL busy_done: got %0d done pulses expected 1", done_cyc.size()); end
        checks++; if (rd_q.size() != 2 || rd_q[0] != b || rd_q[1] != ((b + 1) & AMASK)) begin errors++;
            $display("FAIL busy_reads: got %0d reads expected %0h,%0h", rd_q.size(), b, (b + 1) & AMASK); end
        checks++; if (px_q.size() != 32) begin errors++; $display("FAIL busy_count: got %0d expected 32", px_q.size()); end
    endtask

`ifdef STREAMER_CHECKSUM_EN
    task automatic test_checksum();
        int t0; bit ok;
        all_ff = 1'b1; rmode = 2;
        launch($urandom_range(0, AMASK), 1, t0);
        wait_done(200, ok);
        rmode = 0;
        checks++; if (!ok || done_csum.size() != 1 || done_csum[0] !== 16'h0FF0) begin errors++;
            $display("FAIL csum_done: got %0h expected 0ff0", (done_csum.size() > 0) ? done_csum[0] : 16'hxxxx); end
        repeat (4) @(negedge clk); #1;
        checks++; if (checksum !== 16'h0FF0) begin errors++; $display("FAIL csum_hold: got %0h expected 0ff0", checksum); end
        all_ff = 1'b0;
    endtask
`endif

    task automatic test_random();
        int t0; bit ok; int b; int c; int n;
        for (int it = 0; it < 6; it++) begin
            salt = $urandom_range(0, 255); all_ff = 1'b0; rmode = 2;
            b = $urandom_range(0, AMASK);
            c = $urandom_range(1, 3);
            n = 16 * c;
            build_exp(b, c);
            launch(b, c, t0);
            wait_done(600, ok);
            checks++; if (!ok || px_q != exp_q) begin errors++;
                $display("FAIL rand%0d_stream: got %0d pixels expected %0d matching", it, px_q.size(), n); end
            checks++; if (lst_q.size() != n || lst_q.sum() with (int'(item)) != 1 || lst_q[n-1] != 1'b1) begin errors++;
                $display("FAIL rand%0d_last: got %0d flags expected one on pixel %0d", it, lst_q.size(), n); end
            checks++; if (rd_q.size() != c || rd_q[c-1] != ((b + c - 1) & AMASK)) begin errors++;
                $display("FAIL rand%0d_reads: got %0d reads expected %0d", it, rd_q.size(), c); end
            checks++; if (done_cyc.size() != 1 || px_cyc.size() != n || done_cyc[0] != px_cyc[n-1] + 1) begin errors++;
                $display("FAIL rand%0d_done: got %0d pulses expected 1 right after last pixel", it, done_cyc.size()); end
            checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d expected 0", it, hold_viol); end
`ifdef STREAMER_CHECKSUM_EN
            begin
                logic [15:0] s;
                s = '0;
                foreach (exp_q[i]) s = s + 16'(exp_q[i]);
                checks++; if (done_csum.size() != 1 || done_csum[0] !== s) begin errors++;
                    $display("FAIL rand%0d_csum: got %0h expected %0h", it, (done_csum.size() > 0) ? done_csum[0] : 16'hxxxx, s); end
            end
`endif
        end
        rmode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_wrap();
        test_zero();
        test_abort();
        test_busy_start();
`ifdef STREAMER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
